// File: rtl/serial_digit_sender.sv
// serial_digit_sender: sends a 4-digit BCD code to the password lock one digit
// per strobe, with GAP idle cycles between strobes. In unlock mode it then
// watches the lock lights for up to RESP_WAIT cycles and classifies the outcome.
//
// Optional feature macro: SERIAL_SENDER_ADMIN_EN. When it is defined, a warning
// light seen at CHECK makes the block send the admin sequence 0,1,2,9 before
// the user code. When it is undefined, a warning at CHECK ends the request at
// once with result 11.
//
// Handshake: start is a level request that is sampled only in IDLE. There is
// no queueing. A request made while busy is dropped. done is a one-cycle pulse
// and result is valid with it. result holds its value until the next accept.
// digitStrobe marks each cycle on which the lock must consume digitOut.
module serial_digit_sender #(
  parameter int unsigned GAP       = 0,
  parameter int unsigned RESP_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] code,
  input  logic        progMode,
  input  logic        unlockLight,
  input  logic        errorLight,
  input  logic        warningLight,
  output logic [3:0]  digitOut,
  output logic        digitStrobe,
  output logic        setModeOut,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4,
`ifdef SERIAL_SENDER_ADMIN_EN
    S_ADMIN = 3'd5,
`endif
    S_FIN   = 3'd6
  } state_t;

  localparam logic [3:0] GAP_LD  = 4'(GAP);
  localparam logic [7:0] WAIT_LD = 8'(RESP_WAIT);

  state_t      state_q, state_d;
  logic [15:0] code_q, code_d;
  logic        prog_q, prog_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  result_q, result_d;
  logic [3:0]  last_q, last_d;
  logic [3:0]  user_digit;
  logic        code_bad;
`ifdef SERIAL_SENDER_ADMIN_EN
  // admin_q is set while the next strobe comes from the admin sequence.
  logic        admin_q, admin_d;
  logic [3:0]  admin_digit;
`endif

  // Select the user digit at the current index. The first digit sent is the top nibble.
  always_comb begin
    user_digit = code_q[15:12];
    case (idx_q)
      2'd0: user_digit = code_q[15:12];
      2'd1: user_digit = code_q[11:8];
      2'd2: user_digit = code_q[7:4];
      2'd3: user_digit = code_q[3:0];
      default: user_digit = code_q[15:12];
    endcase
  end

  // A code is rejected if any of its nibbles is not a decimal digit.
  always_comb begin
    code_bad = (code_q[15:12] > 4'd9) | (code_q[11:8] > 4'd9) |
               (code_q[7:4]   > 4'd9) | (code_q[3:0]  > 4'd9);
  end

`ifdef SERIAL_SENDER_ADMIN_EN
  // Fixed admin prefix 0,1,2,9.
  always_comb begin
    admin_digit = 4'd0;
    case (idx_q)
      2'd0: admin_digit = 4'd0;
      2'd1: admin_digit = 4'd1;
      2'd2: admin_digit = 4'd2;
      2'd3: admin_digit = 4'd9;
      default: admin_digit = 4'd0;
    endcase
  end
`endif

  // Next-state logic and datapath updates.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    prog_d   = prog_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    wait_d   = wait_q;
    result_d = result_q;
    last_d   = last_q;
`ifdef SERIAL_SENDER_ADMIN_EN
    admin_d  = admin_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d   = code;
          prog_d   = progMode;
          result_d = 2'b00;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        idx_d = 2'd0;
        if (code_bad) begin
          result_d = 2'b10;
          state_d  = S_FIN;
        end else if (warningLight) begin
`ifdef SERIAL_SENDER_ADMIN_EN
          admin_d = 1'b1;
          state_d = S_ADMIN;
`else
          result_d = 2'b11;
          state_d  = S_FIN;
`endif
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        last_d = user_digit;
        if (idx_q == 2'd3) begin
          if (prog_q) begin
            // In set mode the lock gives no response, so the request ends here.
            result_d = 2'b00;
            state_d  = S_FIN;
          end else begin
            wait_d  = WAIT_LD;
            state_d = S_WAIT;
          end
        end else begin
          idx_d = idx_q + 2'd1;
          if (GAP_LD != 4'd0) begin
            gap_d   = GAP_LD;
            state_d = S_GAP;
          end
        end
      end
`ifdef SERIAL_SENDER_ADMIN_EN
      S_ADMIN: begin
        last_d = admin_digit;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // The user code comes next, starting again at index 0.
          admin_d = 1'b0;
        end
        if (GAP_LD != 4'd0) begin
          gap_d   = GAP_LD;
          state_d = S_GAP;
        end else if (idx_q == 2'd3) begin
          state_d = S_SEND;
        end
      end
`endif
      S_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d = 4'd0;
`ifdef SERIAL_SENDER_ADMIN_EN
          state_d = admin_q ? S_ADMIN : S_SEND;
`else
          state_d = S_SEND;
`endif
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_WAIT: begin
        if (warningLight) begin
          result_d = 2'b11;
          state_d  = S_FIN;
        end else if (unlockLight) begin
          result_d = 2'b01;
          state_d  = S_FIN;
        end else if (errorLight) begin
          result_d = 2'b10;
          state_d  = S_FIN;
        end else if (wait_q <= 8'd1) begin
          wait_d   = 8'd0;
          result_d = 2'b00;
          state_d  = S_FIN;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset is synchronous.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      code_q   <= 16'h0000;
      prog_q   <= 1'b0;
      idx_q    <= 2'd0;
      gap_q    <= 4'd0;
      wait_q   <= 8'd0;
      result_q <= 2'b00;
      last_q   <= 4'hF;
`ifdef SERIAL_SENDER_ADMIN_EN
      admin_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      prog_q   <= prog_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      wait_q   <= wait_d;
      result_q <= result_d;
      last_q   <= last_d;
`ifdef SERIAL_SENDER_ADMIN_EN
      admin_q  <= admin_d;
`endif
    end
  end

  // Moore outputs. They are decoded from registered state only.
  always_comb begin
    digitOut    = 4'hF;
    digitStrobe = 1'b0;
    case (state_q)
      S_SEND: begin
        digitOut    = user_digit;
        digitStrobe = 1'b1;
      end
`ifdef SERIAL_SENDER_ADMIN_EN
      S_ADMIN: begin
        digitOut    = admin_digit;
        digitStrobe = 1'b1;
      end
`endif
      S_GAP: begin
        digitOut = last_q;
      end
      default: begin
        digitOut    = 4'hF;
        digitStrobe = 1'b0;
      end
    endcase
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_FIN);
    result = result_q;
`ifdef SERIAL_SENDER_ADMIN_EN
    setModeOut = busy & prog_q & ~admin_q;
`else
    setModeOut = busy & prog_q;
`endif
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_serial_digit_sender.sv
// tb_serial_digit_sender: scoreboard bench for serial_digit_sender.
// dut0 is built with GAP=0 and dut2 with GAP=2. Both use RESP_WAIT=4.
// Each expected strobe is queued as {cycle, digit} and each expected done as
// {cycle, result}. Monitors pop and compare these entries at the falling edge.
module tb_serial_digit_sender;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start0 = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] code = 16'h0000;
  logic        progMode = 1'b0;
  logic        unlockLight = 1'b0;
  logic        errorLight = 1'b0;
  logic        warningLight = 1'b0;

  logic [3:0] digitOut0, digitOut2;
  logic       digitStrobe0, digitStrobe2, setModeOut0, setModeOut2;
  logic       busy0, busy2, done0, done2;
  logic [1:0] result0, result2;
  logic [2:0] dbg_state0, dbg_state2;

  logic [31:0] cyc = 32'd0;
  int n_checks = 0;
  int n_fail = 0;

  logic [35:0] strb_q0[$];
  logic [35:0] done_q0[$];
  logic [35:0] strb_q2[$];
  logic [35:0] done_q2[$];

  serial_digit_sender #(.GAP(0), .RESP_WAIT(4)) dut0 (
    .CLK(CLK), .RST(RST), .start(start0), .code(code), .progMode(progMode),
    .unlockLight(unlockLight), .errorLight(errorLight), .warningLight(warningLight),
    .digitOut(digitOut0), .digitStrobe(digitStrobe0), .setModeOut(setModeOut0),
    .busy(busy0), .done(done0), .result(result0), .dbg_state(dbg_state0)
  );

  serial_digit_sender #(.GAP(2), .RESP_WAIT(4)) dut2 (
    .CLK(CLK), .RST(RST), .start(start2), .code(code), .progMode(progMode),
    .unlockLight(unlockLight), .errorLight(errorLight), .warningLight(warningLight),
    .digitOut(digitOut2), .digitStrobe(digitStrobe2), .setModeOut(setModeOut2),
    .busy(busy2), .done(done2), .result(result2), .dbg_state(dbg_state2)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 32'd1;

  // Monitor for dut0
  always @(negedge CLK) begin : mon0
    logic [35:0] e;
    if (digitStrobe0 === 1'b1) begin
      n_checks++;
      if (strb_q0.size() == 0) begin
        n_fail++;
        $display("FAIL strobe0_unexpected cyc=%0d digit=%h", cyc, digitOut0);
      end else begin
        e = strb_q0.pop_front();
        if ({cyc, digitOut0} !== e) begin
          n_fail++;
          $display("FAIL strobe0 got cyc=%0d digit=%h expected cyc=%0d digit=%h",
                   cyc, digitOut0, e[35:4], e[3:0]);
        end
      end
    end
    if (done0 === 1'b1) begin
      n_checks++;
      if (done_q0.size() == 0) begin
        n_fail++;
        $display("FAIL done0_unexpected cyc=%0d result=%b", cyc, result0);
      end else begin
        e = done_q0.pop_front();
        if ({cyc, 2'b00, result0} !== e) begin
          n_fail++;
          $display("FAIL done0 got cyc=%0d result=%b expected cyc=%0d result=%b",
                   cyc, result0, e[35:4], e[1:0]);
        end
      end
    end
  end

  // Monitor for dut2
  always @(negedge CLK) begin : mon2
    logic [35:0] e;
    if (digitStrobe2 === 1'b1) begin
      n_checks++;
      if (strb_q2.size() == 0) begin
        n_fail++;
        $display("FAIL strobe2_unexpected cyc=%0d digit=%h", cyc, digitOut2);
      end else begin
        e = strb_q2.pop_front();
        if ({cyc, digitOut2} !== e) begin
          n_fail++;
          $display("FAIL strobe2 got cyc=%0d digit=%h expected cyc=%0d digit=%h",
                   cyc, digitOut2, e[35:4], e[3:0]);
        end
      end
    end
    if (done2 === 1'b1) begin
      n_checks++;
      if (done_q2.size() == 0) begin
        n_fail++;
        $display("FAIL done2_unexpected cyc=%0d result=%b", cyc, result2);
      end else begin
        e = done_q2.pop_front();
        if ({cyc, 2'b00, result2} !== e) begin
          n_fail++;
          $display("FAIL done2 got cyc=%0d result=%b expected cyc=%0d result=%b",
                   cyc, result2, e[35:4], e[1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic start_req(input bit sel, input logic [15:0] c, input logic pm,
                           output logic [31:0] t);
    @(negedge CLK);
    code = c;
    progMode = pm;
    if (sel) start2 = 1'b1;
    else start0 = 1'b1;
    t = cyc;
    @(negedge CLK);
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic push_strobes(input bit sel, input logic [31:0] t, input logic [15:0] c,
                              input int gapv, input int base);
    logic [31:0] when_c;
    for (int k = 0; k < 4; k++) begin
      when_c = t + 32'(2 + (base + k) * (gapv + 1));
      if (sel) strb_q2.push_back({when_c, c[15-4*k -: 4]});
      else strb_q0.push_back({when_c, c[15-4*k -: 4]});
    end
  endtask

  task automatic push_done(input bit sel, input logic [31:0] when_c, input logic [1:0] res);
    if (sel) done_q2.push_back({when_c, 2'b00, res});
    else done_q0.push_back({when_c, 2'b00, res});
  endtask

  task automatic wait_until(input logic [31:0] target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((strb_q0.size() + done_q0.size() + strb_q2.size() + done_q2.size()) > 0
           && n < budget) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if ((strb_q0.size() + done_q0.size() + strb_q2.size() + done_q2.size()) > 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0",
               strb_q0.size() + done_q0.size() + strb_q2.size() + done_q2.size());
      strb_q0.delete(); done_q0.delete(); strb_q2.delete(); done_q2.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  // Scenario tasks
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({digitOut0, digitStrobe0, setModeOut0, busy0, done0, result0} !== 10'b1111_0_0_0_0_00) begin
      n_fail++;
      $display("FAIL reset_dut0 got %h/%b/%b/%b/%b/%b required F/0/0/0/0/00",
               digitOut0, digitStrobe0, setModeOut0, busy0, done0, result0);
    end
    n_checks++;
    if ({digitOut2, digitStrobe2, setModeOut2, busy2, done2, result2} !== 10'b1111_0_0_0_0_00) begin
      n_fail++;
      $display("FAIL reset_dut2 got %h/%b/%b/%b/%b/%b required F/0/0/0/0/00",
               digitOut2, digitStrobe2, setModeOut2, busy2, done2, result2);
    end
    RST = 1'b0;
  endtask

  task automatic test_unlock();
    logic [31:0] t;
    start_req(1'b0, 16'h1234, 1'b0, t);
    push_strobes(1'b0, t, 16'h1234, 0, 0);
    push_done(1'b0, t + 32'd8, 2'b01);
    wait_until(t + 32'd7);
    unlockLight = 1'b1;
    @(negedge CLK);
    unlockLight = 1'b0;
    drain(30);
    n_checks++;
    if ({result0, busy0, digitOut0} !== {2'b01, 1'b0, 4'hF}) begin
      n_fail++;
      $display("FAIL unlock_hold got result=%b busy=%b digit=%h required 01/0/F",
               result0, busy0, digitOut0);
    end
  endtask

  task automatic test_setmode_gap();
    logic [31:0] t;
    start_req(1'b1, 16'h5678, 1'b1, t);
    push_strobes(1'b1, t, 16'h5678, 2, 0);
    push_done(1'b1, t + 32'd12, 2'b00);
    for (int c = 1; c <= 13; c++) begin
      if (c <= 12) begin
        n_checks++;
        if ({setModeOut2, busy2} !== 2'b11) begin
          n_fail++;
          $display("FAIL setmode_busy cyc=t+%0d got set=%b busy=%b required 1/1",
                   c, setModeOut2, busy2);
        end
      end else begin
        n_checks++;
        if ({setModeOut2, busy2} !== 2'b00) begin
          n_fail++;
          $display("FAIL setmode_idle got set=%b busy=%b required 0/0", setModeOut2, busy2);
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({digitOut2, digitStrobe2} !== {4'h5, 1'b0}) begin
          n_fail++;
          $display("FAIL gap_hold got digit=%h strobe=%b required 5/0", digitOut2, digitStrobe2);
        end
      end
      if (c == 4) begin
        code = 16'h9999;
        start2 = 1'b1;
      end
      if (c == 5) start2 = 1'b0;
      @(negedge CLK);
    end
    drain(30);
  endtask

  task automatic test_invalid();
    logic [31:0] t;
    start_req(1'b0, 16'h12A4, 1'b0, t);
    push_done(1'b0, t + 32'd2, 2'b10);
    drain(20);
  endtask

  task automatic test_timeout_and_priority();
    logic [31:0] t;
    logic [2:0]  pats[4];
    logic [1:0]  res;
    start_req(1'b0, 16'h9087, 1'b0, t);
    push_strobes(1'b0, t, 16'h9087, 0, 0);
    push_done(1'b0, t + 32'd10, 2'b00);
    drain(30);
    // light patterns are {warning, unlock, error}
    pats[0] = 3'b101; pats[1] = 3'b011; pats[2] = 3'b001; pats[3] = 3'b110;
    for (int i = 0; i < 4; i++) begin
      if (pats[i][2]) res = 2'b11;
      else if (pats[i][1]) res = 2'b01;
      else res = 2'b10;
      start_req(1'b0, 16'h0246, 1'b0, t);
      push_strobes(1'b0, t, 16'h0246, 0, 0);
      push_done(1'b0, t + 32'd7, res);
      wait_until(t + 32'd6);
      {warningLight, unlockLight, errorLight} = pats[i];
      @(negedge CLK);
      {warningLight, unlockLight, errorLight} = 3'b000;
      drain(30);
    end
  endtask

  task automatic test_warning_start();
    logic [31:0] t;
    warningLight = 1'b1;
    start_req(1'b0, 16'h4321, 1'b0, t);
`ifdef SERIAL_SENDER_ADMIN_EN
    push_strobes(1'b0, t, 16'h0129, 0, 0);
    push_strobes(1'b0, t, 16'h4321, 0, 4);
    push_done(1'b0, t + 32'd14, 2'b00);
`else
    push_done(1'b0, t + 32'd2, 2'b11);
`endif
    wait_until(t + 32'd2);
    warningLight = 1'b0;
    drain(40);
  endtask

  task automatic test_reset_mid();
    logic [31:0] t;
    start_req(1'b0, 16'h5555, 1'b0, t);
    strb_q0.push_back({t + 32'd2, 4'h5});
    strb_q0.push_back({t + 32'd3, 4'h5});
    wait_until(t + 32'd3);
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({digitOut0, digitStrobe0, setModeOut0, busy0, done0, result0} !== 10'b1111_0_0_0_0_00) begin
      n_fail++;
      $display("FAIL reset_mid got %h/%b/%b/%b/%b/%b required F/0/0/0/0/00",
               digitOut0, digitStrobe0, setModeOut0, busy0, done0, result0);
    end
    start0 = 1'b1;
    code = 16'h1111;
    @(negedge CLK);
    start0 = 1'b0;
    RST = 1'b0;
    n_checks++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins got busy=%b required 0", busy0);
    end
    repeat (8) @(negedge CLK);
    drain(5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] t;
    logic [15:0] c;
    logic        bad;
    for (int i = 0; i < 8; i++) begin
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c[4*k +: 4] = 4'($urandom_range(0, 11));
        if (c[4*k +: 4] > 4'd9) bad = 1'b1;
      end
      start_req(1'b0, c, 1'b1, t);
      if (bad) begin
        push_done(1'b0, t + 32'd2, 2'b10);
        wait_until(t + 32'd2);
      end else begin
        push_strobes(1'b0, t, c, 0, 0);
        push_done(1'b0, t + 32'd6, 2'b00);
        wait_until(t + 32'd6);
      end
    end
    drain(20);
  endtask

  // Watchdog
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Main sequence
  initial begin
    test_reset();
    test_unlock();
    test_setmode_gap();
    test_invalid();
    test_timeout_and_priority();
    test_warning_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
